// File: rtl/df_seq_divider.sv
// df_seq_divider: sequential restoring divider, one quotient bit per clock.
// Accepts an unsigned dividend/divisor pair in IDLE, iterates WIDTH cycles in RUN,
// then presents quotient/remainder with a one-cycle done pulse.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; operands captured when start is seen
// RUN   | one restoring-division iteration per cycle, WIDTH cycles
// DONE  | results valid, done high for this single cycle
module df_seq_divider #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem_p;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] trial;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic             last_iter;

    // One restoring step: the WIDTH+1-bit compare decides the quotient bit; when it
    // passes the true difference is below the divisor, so the low WIDTH bits of the
    // subtraction are exact and the top bit can be dropped.
    always_comb begin
        shifted   = {rem_p, dvd[WIDTH-1]};
        ge        = (shifted >= {1'b0, dvs});
        trial     = shifted[WIDTH-1:0] - dvs;
        rem_nxt   = ge ? trial : shifted[WIDTH-1:0];
        quo_nxt   = {dvd[WIDTH-2:0], ge};
        last_iter = (cnt == CW'(WIDTH - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = (divisor == '0) ? S_DONE : S_RUN;
            S_RUN:  if (last_iter) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy = (state == S_RUN);
        done = (state == S_DONE);
    end

    // Datapath: operand capture, iteration, and result registers written on DONE entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd         <= '0;
            dvs         <= '0;
            rem_p       <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dvd   <= dividend;
                        dvs   <= divisor;
                        rem_p <= '0;
                        cnt   <= '0;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    dvd   <= quo_nxt;
                    rem_p <= rem_nxt;
                    cnt   <= cnt + 1'b1;
                    if (last_iter) begin
                        quotient    <= quo_nxt;
                        remainder   <= rem_nxt;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
